// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART transmitter from NUM_REQ byte sources.
// Optional tag byte ahead of each payload when UART_ARB_TAG_EN is defined.
module uart_tx_arbiter #(
  parameter int              NUM_REQ  = 4,
  parameter int              IDX_W    = 2,
  parameter logic [7:0]      TAG_BASE = 8'hF0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]   REQ_ACK,
  input  logic                 TX_RDY,
  output logic                 WEN,
  output logic [7:0]           TX_DATA,
  output logic [IDX_W-1:0]     GRANT_IDX,
  output logic                 BUSY
);

  // Elaboration-time guard on the parameter set.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || IDX_W > 7 ||
        $bits(TAG_BASE) != 8) begin : g_bad_cfg
      $error("uart_tx_arbiter: illegal NUM_REQ/IDX_W combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_HOLD,
    S_WAIT
`ifdef UART_ARB_TAG_EN
    ,
    S_LOAD_TAG,
    S_HOLD_TAG,
    S_WAIT_TAG
`endif
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [7:0]           r_tx_data;
`ifdef UART_ARB_TAG_EN
  logic [7:0]           r_payload;
  logic [7:0]           w_tag;
`endif

  logic                 w_hi_found;
  logic                 w_lo_found;
  logic [IDX_W-1:0]     w_hi_idx;
  logic [IDX_W-1:0]     w_lo_idx;
  logic                 w_found;
  logic [IDX_W-1:0]     w_winner;
  logic [7:0]           w_win_byte;
  logic [NUM_REQ-1:0]   w_ack;
  logic                 w_wen;
  logic                 w_take;

  // Winner search: lowest valid index above the pointer, else lowest at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        if (i > int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDX_W'(i);
        end
      end
    end
    w_found  = w_hi_found | w_lo_found;
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_win_byte = REQ_DATA[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TAG_EN
  assign w_tag = {TAG_BASE[7:IDX_W], w_winner};
`endif

  assign w_take = (r_state == S_GRANT) && w_found;

  always_comb begin
    w_state_nxt = r_state;
    w_wen       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ack[i] = w_take && (w_winner == IDX_W'(i));
    end
    case (r_state)
      S_IDLE: begin
        if (TX_RDY && (|REQ_VALID)) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_found) begin
`ifdef UART_ARB_TAG_EN
          w_state_nxt = S_LOAD_TAG;
`else
          w_state_nxt = S_LOAD;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_wen       = 1'b1;
        w_state_nxt = S_HOLD;
      end
      // The transmitter's ready flag lags the write by a cycle; ignore it here.
      S_HOLD: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (TX_RDY) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      S_LOAD_TAG: begin
        w_wen       = 1'b1;
        w_state_nxt = S_HOLD_TAG;
      end
      S_HOLD_TAG: begin
        w_state_nxt = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        if (TX_RDY) begin
          w_state_nxt = S_LOAD;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_grant_idx <= '0;
      r_tx_data   <= 8'h00;
`ifdef UART_ARB_TAG_EN
      r_payload   <= 8'h00;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_ptr       <= w_winner;
        r_grant_idx <= w_winner;
`ifdef UART_ARB_TAG_EN
        r_tx_data   <= w_tag;
        r_payload   <= w_win_byte;
`else
        r_tx_data   <= w_win_byte;
`endif
      end
`ifdef UART_ARB_TAG_EN
      // Swap the held payload onto the bus once the tag has been accepted.
      if ((r_state == S_WAIT_TAG) && TX_RDY) begin
        r_tx_data <= r_payload;
      end
`endif
    end
  end

  assign REQ_ACK   = w_ack;
  assign WEN       = w_wen;
  assign TX_DATA   = r_tx_data;
  assign GRANT_IDX = r_grant_idx;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a timestamp model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic           tx_rdy = 1'b1;
  logic           wen;
  logic [7:0]     tx_data;
  logic [1:0]     grant_idx;
  logic           busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int tx_mode = 1;
  int tx_hold = 0;
  int multi_ack = 0;
  logic saw_wen;
  logic [N-1:0] last_ack = '0;

  int ack_q[$];
  int ack_cyc_q[$];
  int wen_q[$];
  int wen_cyc_q[$];

  int   m_ptr, m_wen_at, m_wait_from, m_win;
  bit   m_avail, m_arb;
  logic [7:0] m_byte;

  uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(2), .TAG_BASE(8'hF0)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_ACK   (req_ack),
    .TX_RDY    (tx_rdy),
    .WEN       (wen),
    .TX_DATA   (tx_data),
    .GRANT_IDX (grant_idx),
    .BUSY      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Transmitter model: 0 = never ready, 1 = always ready, 2 = busy 10 cycles per write, 3 = random busy time.
  always @(posedge CLK) begin
    saw_wen = wen;
    #1;
    case (tx_mode)
      0: tx_rdy = 1'b0;
      1: tx_rdy = 1'b1;
      default: begin
        if (saw_wen) tx_hold = (tx_mode == 2) ? 10 : int'($urandom_range(0, 6));
        if (tx_hold > 0) begin
          tx_rdy = 1'b0;
          tx_hold--;
        end else begin
          tx_rdy = 1'b1;
        end
      end
    endcase
  end

  // Reference model: each cycle is idle, an arbitration cycle, or busy until a write completes.
  always @(negedge CLK) begin
    logic [N-1:0] e_ack;
    logic         e_wen;
    bit           n_av, n_arb;
    int           w;
    cyc++;
    last_ack = req_ack;
    if ($countones(req_ack) > 1) multi_ack++;
    for (int i = 0; i < N; i++) if (req_ack[i]) begin
      ack_q.push_back(i);
      ack_cyc_q.push_back(cyc);
    end
    if (wen === 1'b1) begin
      wen_q.push_back(int'(tx_data));
      wen_cyc_q.push_back(cyc);
    end
    if (!RESET_N) begin
      m_ptr = N - 1; m_avail = 1; m_arb = 0; m_wen_at = -1; m_wait_from = 0; m_win = 0; m_byte = 8'h00;
      chk("rst_ack", req_ack, 0);
      chk("rst_wen", wen, 0);
      chk("rst_busy", busy, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_gidx", grant_idx, 0);
    end else begin
      e_ack = '0;
      e_wen = (cyc == m_wen_at);
      n_av  = 0;
      n_arb = 0;
      if (m_arb) begin
        w = rr_pick(req_valid, m_ptr);
        if (w >= 0) begin
          e_ack[w]    = 1'b1;
          m_ptr       = w;
          m_win       = w;
          m_byte      = req_data[8*w +: 8];
          m_wen_at    = cyc + 1;
          m_wait_from = cyc + 3;
        end else begin
          n_av = 1;
        end
      end else if (m_avail) begin
        if (tx_rdy && (|req_valid)) n_arb = 1;
        else n_av = 1;
      end else if (cyc >= m_wait_from && tx_rdy) begin
        n_av = 1;
      end
      chk("ack", req_ack, e_ack);
      chk("wen", wen, e_wen);
      chk("busy", busy, !m_avail);
      if (e_wen) begin
        chk("txd", tx_data, m_byte);
        chk("gidx", grant_idx, m_win);
      end
      m_avail = n_av;
      m_arb   = n_arb;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int target, input int limit);
    int k = 0;
    while (ack_q.size() < target && k < limit) begin tick(1); k++; end
    chk("ack_wait", ack_q.size() >= target, 1);
  endtask

  task automatic wait_wen(input int target, input int limit);
    int k = 0;
    while (wen_q.size() < target && k < limit) begin tick(1); k++; end
    chk("wen_wait", wen_q.size() >= target, 1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin tick(1); k++; end
    chk("idle_wait", busy, 0);
  endtask

  task automatic single(input int idx, input logic [7:0] b, output int a0, output int w0);
    a0 = ack_q.size();
    w0 = wen_q.size();
    req_data[8*idx +: 8] = b;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    wait_ack(a0 + 1, 40);
    req_valid = '0;
    wait_wen(w0 + 1, 40);
    chk("single_idx", q_at(ack_q, a0), idx);
    chk("single_byte", q_at(wen_q, w0), b);
  endtask

  initial begin
    int a0, w0;
    int exp_rr[5];
    exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    tick(3);
    RESET_N = 1'b1;

    // Reset while waiting on the transmitter.
    tx_mode = 2;
    single(0, 8'hA5, a0, w0);
    tick(3);
    chk("pre_rst_busy", busy, 1);
    RESET_N = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wen", wen, 0);
    chk("arst_txd", tx_data, 0);
    chk("arst_gidx", grant_idx, 0);
    chk("arst_ack", req_ack, 0);
    tick(2);
    tx_mode = 1;
    RESET_N = 1'b1;

    single(2, 8'h5A, a0, w0);
    chk("lat_ack_wen", q_at(wen_cyc_q, w0) - q_at(ack_cyc_q, a0), 1);
    chk("gidx_after", grant_idx, 2);
    wait_idle(40);

    single(3, 8'h33, a0, w0);
    wait_idle(40);

    // Request withdrawn during its GRANT cycle: nothing happens, pointer stays at 3.
    a0 = ack_q.size();
    w0 = wen_q.size();
    req_valid = 4'b1000;
    tick(1);
    req_valid = '0;
    tick(6);
    chk("wd_ack", ack_q.size(), a0);
    chk("wd_wen", wen_q.size(), w0);
    chk("wd_busy", busy, 0);

    // Round robin with all valid; first grant must be 0.
    tx_mode = 2;
    a0 = ack_q.size();
    w0 = wen_q.size();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    wait_wen(w0 + 5, 400);
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("rr_byte", q_at(wen_q, w0 + i), exp_rr[i]);
    chk("rr_acks", ack_q.size() - a0, 5);
    tx_mode = 1;
    wait_idle(60);

    // Wrap-around from pointer 3.
    single(3, 8'h3C, a0, w0);
    wait_idle(40);
    single(0, 8'h0C, a0, w0);
    wait_idle(40);
    a0 = ack_q.size();
    req_data[15:0] = 16'h1D0D;
    req_valid = 4'b0011;
    wait_ack(a0 + 1, 40);
    req_valid[1] = 1'b0;
    chk("wrap_next", q_at(ack_q, a0), 1);
    tick(2);
    req_valid = '0;
    wait_idle(40);

    // Backpressure: transmitter not ready for 50 cycles.
    tx_mode = 0;
    tick(1);
    a0 = ack_q.size();
    w0 = wen_q.size();
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    tick(50);
    chk("bp_ack", ack_q.size(), a0);
    chk("bp_wen", wen_q.size(), w0);
    tx_mode = 1;
    wait_ack(a0 + 1, 20);
    req_valid = '0;
    wait_wen(w0 + 1, 20);
    chk("bp_idx", q_at(ack_q, a0), 1);
    chk("bp_byte", q_at(wen_q, w0), 8'h77);
    chk("bp_lat", q_at(wen_cyc_q, w0) - q_at(ack_cyc_q, a0), 1);
    wait_idle(40);

    // Randomized traffic checked cycle by cycle by the model.
    tx_mode = 3;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (last_ack[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick(1);
    end
    req_valid = '0;
    tx_mode = 1;
    wait_idle(60);
    chk("onehot_ack", multi_ack, 0);
    chk("rand_traffic", ack_q.size() > 40, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmit path (transmitter with a one-byte holding register) between NUM_REQ byte-stream requesters.
- Takes a byte from the winning requester, issues a single-cycle write strobe to the transmitter, then waits for the transmitter's ready flag before arbitrating again.
- Sits between on-chip byte sources (status reporters, debug/telemetry channels) and the UART transmitter's data/write-enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index (must satisfy 2**IDX_W >= NUM_REQ).
- TAG_BASE, 8'hF0, upper bits of the tag byte; used only with UART_ARB_TAG_EN.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester byte-available flag.
- REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- REQ_ACK  out  NUM_REQ  one-cycle pulse; the byte has been taken.
- TX_RDY  in  1  transmitter holding register empty; 1 = can accept a byte.
- WEN  out  1  one-cycle write strobe to the transmitter.
- TX_DATA  out  8  byte presented to the transmitter; valid while WEN=1.
- GRANT_IDX  out  IDX_W  index of the most recently granted requester.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State = IDLE.
  - REQ_ACK = 0, WEN = 0, TX_DATA = 8'h00, GRANT_IDX = 0, BUSY = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has priority first.
  - No partially started write is resumed after reset.
- FSM states: IDLE, GRANT, LOAD, HOLD, WAIT.
  - IDLE: if TX_RDY=1 and any REQ_VALID=1, go to GRANT. Otherwise stay.
  - GRANT: select the winner, searching from pointer+1 upward modulo NUM_REQ and taking the first requester with REQ_VALID=1.
    - Latch its byte into TX_DATA, pulse REQ_ACK[winner] for this cycle only, set GRANT_IDX = pointer = winner, go to LOAD.
    - If all REQ_VALID have dropped: no ACK, pointer unchanged, return to IDLE.
  - LOAD: WEN=1 for exactly one cycle; TX_DATA holds the latched byte. Go to HOLD.
  - HOLD: one cycle in which TX_RDY is ignored, to cover the transmitter's flag-update latency. Go to WAIT.
  - WAIT: stay until TX_RDY=1, then go to IDLE.
- Latency: REQ_VALID sampled high at edge N with TX_RDY=1 and the FSM in IDLE gives REQ_ACK during cycle N+1 and WEN during cycle N+2.
- Handshake rules:
  - A requester holds REQ_VALID and REQ_DATA stable until it sees REQ_ACK.
  - A requester may drop REQ_VALID before it is granted; it then loses its turn without error.
  - REQ_DATA is sampled only in GRANT.
  - At most one REQ_ACK bit is high in any cycle; REQ_ACK and WEN are never high in the same cycle.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,... Pointer wrap-around from NUM_REQ-1 back to 0 is required.
- TX_RDY=0 in IDLE: no arbitration, no ACK; requests remain pending.
- TX_DATA keeps its last value outside LOAD.
- REQ_VALID bits above NUM_REQ-1 do not exist; the pointer never exceeds NUM_REQ-1.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined: each payload byte is preceded by a tag byte = {TAG_BASE[7:IDX_W], winner index}.
  - Sequence: GRANT -> LOAD_TAG (WEN=1 with the tag) -> HOLD_TAG -> WAIT_TAG (until TX_RDY=1) -> LOAD -> HOLD -> WAIT -> IDLE.
  - REQ_ACK is still pulsed in GRANT; the payload byte is latched in GRANT into a separate register.
  - Reset during any tag state returns the FSM to IDLE with no payload sent.
- Undefined: tag states, the payload latch and TAG_BASE logic are absent; behaviour is exactly the base FSM above.

Test Plan:
- Reset: drive RESET_N=0 mid-WAIT -> all outputs 0 immediately; after release with REQ_VALID[2]=1, REQ_DATA[2]=8'h5A, TX_RDY=1 -> REQ_ACK=4'b0100 at N+1, WEN=1 with TX_DATA=8'h5A at N+2, GRANT_IDX=2.
- Round robin: all four requesters valid with bytes 8'h10..8'h13, transmitter model drops TX_RDY for 10 cycles after each WEN -> WEN bytes appear in order 10,11,12,13,10; no two REQ_ACK bits ever high together.
- Backpressure: TX_RDY held 0 for 50 cycles while REQ_VALID[1]=1 -> no ACK and no WEN; TX_RDY rises -> ACK[1] one cycle later, WEN the cycle after.
- Withdrawn request: REQ_VALID[3] pulsed for one cycle with TX_RDY=1, dropped in the GRANT cycle -> no ACK, no WEN, FSM back in IDLE, pointer unchanged (the next grant with all valid goes to requester 0).
- Wrap: pointer at 3 with only requester 0 valid -> requester 0 granted; then requesters 0 and 1 valid -> requester 1 granted next.
- Tag (UART_ARB_TAG_EN defined, TAG_BASE=8'hF0): requester 2 sends 8'h41 -> WEN bytes are 8'hF2 then 8'h41, each gated by TX_RDY returning high; ACK[2] pulses once.
